// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU request scheduler: opcode encodings,
// FSM state type and the latched request record.
package alu_sched_pkg;

    localparam int SCHED_WIDTH = 64;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_MAX   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam int         OP_COUNT = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [3:0]             opcode;
        logic [SCHED_WIDTH-1:0] input1;
        logic [SCHED_WIDTH-1:0] input2;
        logic [4:0]             shiftValue;
        logic                   id;
    } alu_req_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op < 4'(OP_COUNT);
    endfunction

endpackage

// File: rtl/alu_rr_arbiter2.sv
// Two-way round-robin arbiter. Grants only while enabled; the pointer
// moves to the requester that was not granted, so a busy pair alternates.
module alu_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_enable,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // grant decode: a lone requester wins, a tie goes to the pointer
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
                default: o_grant = 2'b00;
            endcase
        end
    end

    // pointer favours the other requester after every grant
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b0;
        else if (|o_grant)
            r_ptr <= ~o_grant[1];
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU between two requesters: accept, drive the
// ALU from registered operands, capture result/flags, return a tagged
// response. Build option ALU_SCHED_MUL_MULTICYCLE_EN holds MUL on the ALU
// for MUL_LATENCY cycles; without it MUL takes one cycle like every op.
//
//   state | meaning
//   IDLE  | ready follows the arbiter grant, waiting for a request
//   EXEC  | ALU inputs held from drive registers, result captured on exit
//   RESP  | response presented until rsp_ready
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int MUL_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_input1,
    input  logic [WIDTH-1:0] req0_input2,
    input  logic [4:0]       req0_shiftValue,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_input1,
    input  logic [WIDTH-1:0] req1_input2,
    input  logic [4:0]       req1_shiftValue,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryFlag,
    input  logic             alu_zeroFlag,
    input  logic             alu_signFlag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryFlag,
    output logic             rsp_zeroFlag,
    output logic             rsp_signFlag
);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    alu_req_t         r_drv;
    alu_req_t         w_req_sel;
    logic [1:0]       w_grant;
    logic             w_idle;
    logic             w_accept;
    logic             w_legal;
    logic             w_exec_done;

    logic             r_rsp_id;
    logic             r_rsp_err;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_carry;
    logic             r_rsp_zero;
    logic             r_rsp_sign;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = |w_grant;
    assign w_legal  = op_is_legal(w_req_sel.opcode);

    alu_rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_valid  ({req1_valid, req0_valid}),
        .i_enable (w_idle),
        .o_grant  (w_grant)
    );

    // select the granted requester's fields as one record
    always_comb begin
        w_req_sel = '0;
        if (w_grant[1]) begin
            w_req_sel.opcode     = req1_opcode;
            w_req_sel.input1     = req1_input1;
            w_req_sel.input2     = req1_input2;
            w_req_sel.shiftValue = req1_shiftValue;
            w_req_sel.id         = 1'b1;
        end else begin
            w_req_sel.opcode     = req0_opcode;
            w_req_sel.input1     = req0_input1;
            w_req_sel.input2     = req0_input2;
            w_req_sel.shiftValue = req0_shiftValue;
            w_req_sel.id         = 1'b0;
        end
    end

`ifdef ALU_SCHED_MUL_MULTICYCLE_EN
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    logic [CNT_W-1:0] r_mul_cnt;

    // MUL residency counter: loaded at accept, counts down through EXEC
    always_ff @(posedge clk) begin
        if (rst)
            r_mul_cnt <= '0;
        else if (w_accept && w_legal && (w_req_sel.opcode == OP_MUL))
            r_mul_cnt <= CNT_W'(MUL_LATENCY - 1);
        else if ((r_state == ST_EXEC) && (r_mul_cnt != '0))
            r_mul_cnt <= r_mul_cnt - 1'b1;
    end

    assign w_exec_done = (r_state == ST_EXEC) && (r_mul_cnt == '0);
`else
    localparam int MUL_LATENCY_UNUSED = MUL_LATENCY;

    assign w_exec_done = (r_state == ST_EXEC);
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_grant[0];
                req1_ready = w_grant[1];
                if (w_accept)
                    w_state_nxt = w_legal ? ST_EXEC : ST_RESP;
            end
            ST_EXEC: begin
                if (w_exec_done)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU drive registers: loaded only for legal ops, held otherwise
    always_ff @(posedge clk) begin
        if (rst)
            r_drv <= '0;
        else if (w_accept && w_legal)
            r_drv <= w_req_sel;
    end

    // response registers: synthetic error response or captured ALU output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_sign   <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_rsp_id     <= w_req_sel.id;
            r_rsp_err    <= 1'b1;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b1;
            r_rsp_sign   <= 1'b0;
        end else if (w_exec_done) begin
            r_rsp_id     <= r_drv.id;
            r_rsp_err    <= 1'b0;
            r_rsp_result <= alu_result;
            r_rsp_carry  <= alu_carryFlag;
            r_rsp_zero   <= alu_zeroFlag;
            r_rsp_sign   <= alu_signFlag;
        end
    end

    assign alu_opcode     = r_drv.opcode;
    assign alu_input1     = r_drv.input1;
    assign alu_input2     = r_drv.input2;
    assign alu_shiftValue = r_drv.shiftValue;

    assign rsp_id         = r_rsp_id;
    assign rsp_err        = r_rsp_err;
    assign rsp_result     = r_rsp_result;
    assign rsp_carryFlag  = r_rsp_carry;
    assign rsp_zeroFlag   = r_rsp_zero;
    assign rsp_signFlag   = r_rsp_sign;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: a behavioural ALU answers the scheduler's
// drive, and a transaction-level model predicts grant order, latency,
// response contents and the held ALU drive.
`timescale 1ns/1ps
module tb_alu_req_scheduler;

    localparam int W       = 64;
    localparam int MUL_LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_opcode, req1_opcode;
    logic [W-1:0] req0_input1, req0_input2, req1_input1, req1_input2;
    logic [4:0]   req0_shiftValue, req1_shiftValue;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_input1, alu_input2, alu_result;
    logic [4:0]   alu_shiftValue;
    logic         alu_carryFlag, alu_zeroFlag, alu_signFlag;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W-1:0] rsp_result;
    logic         rsp_carryFlag, rsp_zeroFlag, rsp_signFlag;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic         m_ptr;
    logic [3:0]   m_op;
    logic [W-1:0] m_a, m_b;
    logic [4:0]   m_sh;

    always #5 clk = ~clk;

    alu_req_scheduler #(.WIDTH(W), .MUL_LATENCY(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_input1(req0_input1), .req0_input2(req0_input2), .req0_shiftValue(req0_shiftValue),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_input1(req1_input1), .req1_input2(req1_input2), .req1_shiftValue(req1_shiftValue),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
        .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag), .alu_signFlag(alu_signFlag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_result(rsp_result), .rsp_carryFlag(rsp_carryFlag),
        .rsp_zeroFlag(rsp_zeroFlag), .rsp_signFlag(rsp_signFlag)
    );

    // behavioural ALU: returns {carry, zero, sign, result}
    function automatic logic [W+2:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [4:0] sh);
        logic [W:0]     wide;
        logic [2*W-1:0] prod;
        logic [W-1:0]   r;
        logic           c;
        r = '0;
        c = 1'b0;
        case (op)
            4'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: begin
                prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = prod[W-1:0];
                c = |prod[2*W-1:W];
            end
            4'd5: r = ~(a | b);
            4'd6: r = a << sh;
            4'd7: r = (a < b) ? W'(1) : W'(0);
            4'd8: r = (a > b) ? a : b;
            4'd9: r = b;
            default: r = '0;
        endcase
        return {c, (r == '0), r[W-1], r};
    endfunction

    assign {alu_carryFlag, alu_zeroFlag, alu_signFlag, alu_result} =
        alu_fn(alu_opcode, alu_input1, alu_input2, alu_shiftValue);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // requests seen while the scheduler is busy: anything may change
    task automatic scramble();
        req0_valid      = 1'($urandom_range(0, 1));
        req1_valid      = 1'($urandom_range(0, 1));
        req0_opcode     = 4'($urandom_range(0, 15));
        req1_opcode     = 4'($urandom_range(0, 15));
        req0_input1     = rand64();
        req0_input2     = rand64();
        req1_input1     = rand64();
        req1_input2     = rand64();
        req0_shiftValue = 5'($urandom_range(0, 31));
        req1_shiftValue = 5'($urandom_range(0, 31));
    endtask

    // One transaction, entered and left on a falling edge.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [3:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [4:0] s0,
                           input logic [3:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input logic [4:0] s1,
                           input int stall, input bit rst_mid);
        logic         g;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [4:0]   sh;
        logic         legal;
        logic [W+2:0] exp;
        int           exp_lat;
        int           lat;
        bit           seen;

        req0_valid = v0; req0_opcode = op0; req0_input1 = a0; req0_input2 = b0; req0_shiftValue = s0;
        req1_valid = v1; req1_opcode = op1; req1_input1 = a1; req1_input2 = b1; req1_shiftValue = s1;
        rsp_ready  = 1'b0;

        g  = (v0 && v1) ? m_ptr : v1;
        op = g ? op1 : op0;
        a  = g ? a1 : a0;
        b  = g ? b1 : b0;
        sh = g ? s1 : s0;
        legal = (op <= 4'd9);

        #1;
        check("ready0", req0_ready, !g);
        check("ready1", req1_ready, g);

        @(posedge clk);
        m_ptr = ~g;
        if (legal) begin
            m_op = op; m_a = a; m_b = b; m_sh = sh;
            exp = alu_fn(op, a, b, sh);
`ifdef ALU_SCHED_MUL_MULTICYCLE_EN
            exp_lat = (op == 4'd4) ? MUL_LAT + 1 : 2;
`else
            exp_lat = 2;
`endif
        end else begin
            exp = {1'b0, 1'b1, 1'b0, {W{1'b0}}};
            exp_lat = 1;
        end

        @(negedge clk);
        scramble();

        if (rst_mid) begin
            rst = 1'b1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            @(posedge clk);
            #1;
            check("rst_rsp_valid", rsp_valid, 1'b0);
            check("rst_alu_drive", {alu_opcode, alu_input1, alu_input2, alu_shiftValue}, '0);
            check("rst_rsp_fields",
                  {rsp_id, rsp_err, rsp_carryFlag, rsp_zeroFlag, rsp_signFlag, rsp_result}, '0);
            check("rst_ready", {req1_ready, req0_ready}, 2'b00);
            @(negedge clk);
            rst = 1'b0;
            m_ptr = 1'b0;
            m_op = '0; m_a = '0; m_b = '0; m_sh = '0;
            return;
        end

        lat  = 1;
        seen = 1'b0;
        while (lat <= 20) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            check("busy_ready", {req1_ready, req0_ready}, 2'b00);
            check("exec_alu_drive", {alu_opcode, alu_input1, alu_input2, alu_shiftValue},
                  {m_op, m_a, m_b, m_sh});
            @(negedge clk);
            scramble();
            lat++;
        end
        if (!seen) begin
            check("rsp_timeout", 1'b0, 1'b1);
            return;
        end

        check("latency", lat, exp_lat);
        check("rsp_id", rsp_id, g);
        check("rsp_err", rsp_err, !legal);
        check("rsp_result", rsp_result, exp[W-1:0]);
        check("rsp_flags", {rsp_carryFlag, rsp_zeroFlag, rsp_signFlag}, exp[W+2:W]);
        check("resp_alu_drive", {alu_opcode, alu_input1, alu_input2, alu_shiftValue},
              {m_op, m_a, m_b, m_sh});

        for (int i = 0; i < stall; i++) begin
            check("stall_ready", {req1_ready, req0_ready}, 2'b00);
            @(negedge clk);
            scramble();
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_hold", {rsp_id, rsp_err, rsp_carryFlag, rsp_zeroFlag, rsp_signFlag, rsp_result},
                  {g, !legal, exp[W+2:W], exp[W-1:0]});
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_released", rsp_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_opcode = '0; req0_input1 = '0; req0_input2 = '0; req0_shiftValue = '0;
        req1_valid = 1'b0; req1_opcode = '0; req1_input1 = '0; req1_input2 = '0; req1_shiftValue = '0;
        m_ptr = 1'b0;
        m_op = '0; m_a = '0; m_b = '0; m_sh = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_alu_drive", {alu_opcode, alu_input1, alu_input2, alu_shiftValue}, '0);
        check("reset_rsp_fields",
              {rsp_id, rsp_err, rsp_carryFlag, rsp_zeroFlag, rsp_signFlag, rsp_result}, '0);
        rst = 1'b0;

        // tie after reset: SUB from req0 first, then OR from req1
        run_txn(1, 1, 4'd1, 64'd3, 64'd3, 5'd0, 4'd3, 64'hF0, 64'h0F, 5'd0, 0, 0);
        run_txn(1, 1, 4'd1, 64'd3, 64'd3, 5'd0, 4'd3, 64'hF0, 64'h0F, 5'd0, 0, 0);
        // lone ADD from req0
        run_txn(1, 0, 4'd0, 64'd5, 64'd7, 5'd0, 4'd0, 64'd0, 64'd0, 5'd0, 0, 0);
        // illegal opcode from req1
        run_txn(0, 1, 4'd0, 64'd0, 64'd0, 5'd0, 4'd12, 64'd9, 64'd9, 5'd3, 0, 0);
        // SLL with response back-pressure
        run_txn(1, 0, 4'd6, 64'd1, 64'd0, 5'd5, 4'd0, 64'd0, 64'd0, 5'd0, 6, 0);
        // MUL
        run_txn(1, 0, 4'd4, 64'h10, 64'h10, 5'd0, 4'd0, 64'd0, 64'd0, 5'd0, 1, 0);
        // reset during MUL execution, then a tie must go to req0 again
        run_txn(1, 0, 4'd4, 64'h10, 64'h10, 5'd0, 4'd0, 64'd0, 64'd0, 5'd0, 0, 1);
        run_txn(1, 1, 4'd9, 64'd1, 64'hABCD, 5'd0, 4'd2, 64'hFF, 64'h0F, 5'd0, 0, 0);

        for (int t = 0; t < 200; t++) begin
            logic [1:0] vv;
            vv = 2'($urandom_range(1, 3));
            run_txn(vv[0], vv[1],
                    4'($urandom_range(0, 15)), rand64(), rand64(), 5'($urandom_range(0, 31)),
                    4'($urandom_range(0, 15)), rand64(), rand64(), 5'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
